// File: rtl/crc_pkg.sv
// Shared types and helpers for the streaming CRC engine: state enum,
// bit-reverse helper and well-known polynomial/init constants.
package crc_pkg;

    typedef enum logic {ACCUM, HOLD} crc_state_e;

    localparam logic [31:0] CRC8_POLY        = 32'h0000_0007;
    localparam logic [31:0] CRC8_INIT        = 32'h0000_0000;
    localparam logic [31:0] CRC16_CCITT_POLY = 32'h0000_1021;
    localparam logic [31:0] CRC16_CCITT_INIT = 32'h0000_FFFF;
    localparam logic [31:0] CRC32_POLY       = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT       = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOR_OUT    = 32'hFFFF_FFFF;

    // Reverses the low `width` bits of v; bits at and above `width` come back zero.
    function automatic logic [31:0] bit_rev(input logic [31:0] v, input int width);
        logic [31:0] r;
        int          j;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            j = width - 1 - i;
            if (j >= 0) r[i] = v[j[4:0]];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational CRC advance: folds one DATA_WIDTH word (MSB byte first,
// each byte MSB bit first) into the current register.
module crc_step
    import crc_pkg::*;
#(
    parameter int          CRC_WIDTH  = 8,
    parameter logic [31:0] POLYNOMIAL = 32'h07,
    parameter int          DATA_WIDTH = 8,
    parameter bit          REFLECT_IN = 1'b0
) (
    input  logic [CRC_WIDTH-1:0]  crc_cur,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [CRC_WIDTH-1:0]  crc_nxt
);

    localparam int                   NBYTES = DATA_WIDTH / 8;
    localparam logic [CRC_WIDTH-1:0] POLY   = POLYNOMIAL[CRC_WIDTH-1:0];

    logic [CRC_WIDTH-1:0] crc_v;
    logic [7:0]           byte_v;
    logic                 fb;

    always_comb begin
        crc_v  = crc_cur;
        byte_v = '0;
        fb     = 1'b0;
        for (int b = 0; b < NBYTES; b++) begin
            byte_v = data[DATA_WIDTH-1-8*b -: 8];
            if (REFLECT_IN) byte_v = 8'(bit_rev(32'(byte_v), 8));
            // Shifting by 1 keeps CRC_WIDTH=1 legal (no [W-2:0] slice).
            for (int i = 7; i >= 0; i--) begin
                fb    = crc_v[CRC_WIDTH-1] ^ byte_v[i];
                crc_v = (crc_v << 1) ^ (fb ? POLY : '0);
            end
        end
        crc_nxt = crc_v;
    end

endmodule

// File: rtl/crc_stream.sv
// Parametrised streaming CRC engine with valid/ready input and result handshakes.
// Optional residue check (match_o) is built when CRC_STREAM_CHECK_EN is defined.
module crc_stream
    import crc_pkg::*;
#(
    parameter int          CRC_WIDTH     = 8,
    parameter logic [31:0] POLYNOMIAL    = 32'h07,
    parameter logic [31:0] INIT          = 32'h0,
    parameter logic [31:0] XOR_OUT       = 32'h0,
    parameter int          DATA_WIDTH    = 8,
    parameter bit          REFLECT_IN    = 1'b0,
    parameter bit          REFLECT_OUT   = 1'b0
`ifdef CRC_STREAM_CHECK_EN
  , parameter logic [31:0] CHECK_RESIDUE = 32'h0
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    input  logic                  data_last_i,
    output logic                  data_ready_o,
    output logic [CRC_WIDTH-1:0]  crc_o,
    output logic [CRC_WIDTH-1:0]  result_o,
    output logic                  result_valid_o,
`ifdef CRC_STREAM_CHECK_EN
    output logic                  match_o,
`endif
    input  logic                  result_ready_i
);

    localparam logic [CRC_WIDTH-1:0] INIT_W = INIT[CRC_WIDTH-1:0];
    localparam logic [CRC_WIDTH-1:0] XOR_W  = XOR_OUT[CRC_WIDTH-1:0];

    crc_state_e           state_q, state_d;
    logic [CRC_WIDTH-1:0] crc_q, crc_nxt, result_q, final_crc;
    logic                 accept, last_acc;

    assign result_valid_o = (state_q == HOLD);
    assign data_ready_o   = !result_valid_o || result_ready_i;
    assign accept         = data_valid_i && data_ready_o;
    assign last_acc       = accept && data_last_i;

    crc_step #(
        .CRC_WIDTH  (CRC_WIDTH),
        .POLYNOMIAL (POLYNOMIAL),
        .DATA_WIDTH (DATA_WIDTH),
        .REFLECT_IN (REFLECT_IN)
    ) u_step (
        .crc_cur (crc_q),
        .data    (data_i),
        .crc_nxt (crc_nxt)
    );

    assign final_crc = (REFLECT_OUT ? CRC_WIDTH'(bit_rev(32'(crc_nxt), CRC_WIDTH))
                                    : crc_nxt) ^ XOR_W;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ACCUM;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (last_acc) state_d = HOLD;
            HOLD:    if (last_acc)            state_d = HOLD;
                     else if (result_ready_i) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // A last word restarts the register at INIT so the next word opens a new frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q    <= INIT_W;
            result_q <= '0;
        end else begin
            if (accept)   crc_q    <= data_last_i ? INIT_W : crc_nxt;
            if (last_acc) result_q <= final_crc;
        end
    end

    assign crc_o    = crc_q;
    assign result_o = result_q;

`ifdef CRC_STREAM_CHECK_EN
    localparam logic [CRC_WIDTH-1:0] RESIDUE_W = CHECK_RESIDUE[CRC_WIDTH-1:0];
    logic match_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)         match_q <= 1'b0;
        else if (last_acc) match_q <= (crc_nxt == RESIDUE_W);
    end

    assign match_o = match_q;
`endif

endmodule

// File: tb/tb_crc_stream.sv
// Self-checking bench for crc_stream: four configurations (CRC-8, CRC-16/CCITT-FALSE
// on 8- and 16-bit words, reflected CRC-32) against a table-driven reference model.
module tb_crc_stream;

    localparam int          CW   [4] = '{8, 16, 16, 32};
    localparam logic [31:0] POLY [4] = '{32'h07, 32'h1021, 32'h1021, 32'h04C11DB7};
    localparam logic [31:0] INI  [4] = '{32'h0, 32'hFFFF, 32'hFFFF, 32'hFFFFFFFF};
    localparam logic [31:0] XO   [4] = '{32'h0, 32'h0, 32'h0, 32'hFFFFFFFF};
    localparam bit          RIN  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam bit          ROUT [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam int          NB   [4] = '{1, 1, 2, 1};
    localparam logic [31:0] RES  [4] = '{32'h0, 32'h0, 32'h0, 32'h0};

    logic        clk = 1'b0;
    logic [3:0]  rst, dv, dl, rr, rdy, vld;
    logic [7:0]  d0, d1, d3;
    logic [15:0] d2;
    logic [7:0]  c0, r0;
    logic [15:0] c1, r1, c2, r2;
    logic [31:0] c3, r3;
    logic [31:0] crc_a [4];
    logic [31:0] res_a [4];
`ifdef CRC_STREAM_CHECK_EN
    logic [3:0]  mt;
`endif

    int asserts = 0;
    int fails   = 0;

    logic [31:0] ecrc [4];
    logic [31:0] eres [4];
    bit          evld [4];
    bit          ematch [4];

    always #5 clk = ~clk;

    assign crc_a[0] = 32'(c0); assign res_a[0] = 32'(r0);
    assign crc_a[1] = 32'(c1); assign res_a[1] = 32'(r1);
    assign crc_a[2] = 32'(c2); assign res_a[2] = 32'(r2);
    assign crc_a[3] = c3;      assign res_a[3] = r3;

    crc_stream #(.CRC_WIDTH(8), .POLYNOMIAL(32'h07), .INIT(32'h0), .XOR_OUT(32'h0),
                 .DATA_WIDTH(8), .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0)
`ifdef CRC_STREAM_CHECK_EN
               , .CHECK_RESIDUE(32'h0)
`endif
    ) dut0 (.clk_i(clk), .rst_i(rst[0]), .data_i(d0), .data_valid_i(dv[0]), .data_last_i(dl[0]),
            .data_ready_o(rdy[0]), .crc_o(c0), .result_o(r0), .result_valid_o(vld[0]),
`ifdef CRC_STREAM_CHECK_EN
            .match_o(mt[0]),
`endif
            .result_ready_i(rr[0]));

    crc_stream #(.CRC_WIDTH(16), .POLYNOMIAL(32'h1021), .INIT(32'hFFFF), .XOR_OUT(32'h0),
                 .DATA_WIDTH(8), .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0)
`ifdef CRC_STREAM_CHECK_EN
               , .CHECK_RESIDUE(32'h0)
`endif
    ) dut1 (.clk_i(clk), .rst_i(rst[1]), .data_i(d1), .data_valid_i(dv[1]), .data_last_i(dl[1]),
            .data_ready_o(rdy[1]), .crc_o(c1), .result_o(r1), .result_valid_o(vld[1]),
`ifdef CRC_STREAM_CHECK_EN
            .match_o(mt[1]),
`endif
            .result_ready_i(rr[1]));

    crc_stream #(.CRC_WIDTH(16), .POLYNOMIAL(32'h1021), .INIT(32'hFFFF), .XOR_OUT(32'h0),
                 .DATA_WIDTH(16), .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0)
`ifdef CRC_STREAM_CHECK_EN
               , .CHECK_RESIDUE(32'h0)
`endif
    ) dut2 (.clk_i(clk), .rst_i(rst[2]), .data_i(d2), .data_valid_i(dv[2]), .data_last_i(dl[2]),
            .data_ready_o(rdy[2]), .crc_o(c2), .result_o(r2), .result_valid_o(vld[2]),
`ifdef CRC_STREAM_CHECK_EN
            .match_o(mt[2]),
`endif
            .result_ready_i(rr[2]));

    crc_stream #(.CRC_WIDTH(32), .POLYNOMIAL(32'h04C11DB7), .INIT(32'hFFFFFFFF),
                 .XOR_OUT(32'hFFFFFFFF), .DATA_WIDTH(8), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)
`ifdef CRC_STREAM_CHECK_EN
               , .CHECK_RESIDUE(32'h0)
`endif
    ) dut3 (.clk_i(clk), .rst_i(rst[3]), .data_i(d3), .data_valid_i(dv[3]), .data_last_i(dl[3]),
            .data_ready_o(rdy[3]), .crc_o(c3), .result_o(r3), .result_valid_o(vld[3]),
`ifdef CRC_STREAM_CHECK_EN
            .match_o(mt[3]),
`endif
            .result_ready_i(rr[3]));

    // ---------------- reference model (byte-table CRC) ----------------
    function automatic logic [31:0] mask(int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

    function automatic logic [31:0] rev(logic [31:0] v, int w);
        logic [31:0] r = '0;
        for (int i = 0; i < w; i++) r[w-1-i] = v[i];
        return r;
    endfunction

    function automatic logic [31:0] mstep(int k, logic [31:0] c, logic [7:0] b);
        logic [31:0] t;
        logic [7:0]  idx;
        int          w = CW[k];
        if (RIN[k]) b = 8'(rev(32'(b), 8));
        idx = 8'((c >> (w - 8)) ^ 32'(b));
        t   = 32'(idx) << (w - 8);
        for (int i = 0; i < 8; i++) t = t[w-1] ? ((t << 1) ^ POLY[k]) : (t << 1);
        return ((c << 8) ^ t) & mask(w);
    endfunction

    function automatic logic [31:0] mfinal(int k, logic [31:0] raw);
        return ((ROUT[k] ? rev(raw, CW[k]) : raw) ^ XO[k]) & mask(CW[k]);
    endfunction

    function automatic logic [31:0] crc_of(int k, string s);
        logic [31:0] c = INI[k];
        for (int i = 0; i < s.len(); i++) c = mstep(k, c, s[i]);
        return mfinal(k, c);
    endfunction

    function automatic logic [15:0] get_w(int k);
        case (k)
            0:       return {8'h0, d0};
            1:       return {8'h0, d1};
            2:       return d2;
            default: return {8'h0, d3};
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        asserts++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model advances on each rising edge from the inputs the DUTs see; outputs checked 1ns later.
    always @(posedge clk) begin
        bit          acc, nv;
        logic [31:0] c;
        logic [15:0] w;
        for (int k = 0; k < 4; k++) begin
            if (rst[k]) begin
                ecrc[k] = INI[k]; eres[k] = '0; evld[k] = 1'b0; ematch[k] = 1'b0;
            end else begin
                acc = dv[k] && (!evld[k] || rr[k]);
                nv  = evld[k] && !rr[k];
                if (acc) begin
                    w = get_w(k);
                    c = ecrc[k];
                    for (int b = 0; b < NB[k]; b++) c = mstep(k, c, 8'(w >> (8 * (NB[k] - 1 - b))));
                    if (dl[k]) begin
                        eres[k] = mfinal(k, c); ematch[k] = (c == RES[k]);
                        nv = 1'b1; ecrc[k] = INI[k];
                    end else begin
                        ecrc[k] = c;
                    end
                end
                evld[k] = nv;
            end
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("dut%0d crc_o", k), crc_a[k], ecrc[k]);
            chk($sformatf("dut%0d result_valid_o", k), 32'(vld[k]), 32'(evld[k]));
            chk($sformatf("dut%0d data_ready_o", k), 32'(rdy[k]), 32'(!evld[k] || rr[k]));
            if (evld[k]) begin
                chk($sformatf("dut%0d result_o", k), res_a[k], eres[k]);
`ifdef CRC_STREAM_CHECK_EN
                chk($sformatf("dut%0d match_o", k), 32'(mt[k]), 32'(ematch[k]));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_data(int k, logic [15:0] w);
        case (k)
            0:       d0 = w[7:0];
            1:       d1 = w[7:0];
            2:       d2 = w;
            default: d3 = w[7:0];
        endcase
    endtask

    // Called at a falling edge; returns at the falling edge after the word is accepted.
    task automatic send(int k, logic [15:0] w, bit last);
        bit acc;
        int n = 0;
        set_data(k, w); dv[k] = 1'b1; dl[k] = last;
        while (1) begin
            #1 acc = rdy[k];
            @(negedge clk);
            if (acc) break;
            if (++n > 50) begin
                asserts++; fails++;
                $display("FAIL send timeout dut%0d: got no ready expected ready within 50 cycles", k);
                break;
            end
        end
        dv[k] = 1'b0; dl[k] = 1'b0;
    endtask

    task automatic send_str(int k, string s, bit last);
        for (int i = 0; i < s.len(); i++) send(k, 16'(s[i]), last && (i == s.len() - 1));
    endtask

    initial begin
        rst = 4'hF; dv = '0; dl = '0; rr = 4'hF;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        repeat (3) @(negedge clk);
        rst = '0;

        chk("reset crc8 crc_o", crc_a[0], 32'h00);
        chk("reset result_o", res_a[0], 32'h00);
        chk("reset result_valid_o", 32'(vld[0]), 32'h0);
        chk("reset data_ready_o", 32'(rdy[0]), 32'h1);
        chk("reset crc16 crc_o", crc_a[1], 32'hFFFF);
        chk("reset crc32 crc_o", crc_a[3], 32'hFFFF_FFFF);

        chk("model crc8 check", crc_of(0, "123456789"), 32'hF4);
        chk("model crc16 check", crc_of(1, "123456789"), 32'h29B1);
        chk("model crc32 check", crc_of(3, "123456789"), 32'hCBF4_3926);

        send_str(0, "123456789", 1'b1);
        chk("crc8 result", res_a[0], 32'hF4);
        chk("crc8 valid", 32'(vld[0]), 32'h1);
        chk("crc8 crc_o back to init", crc_a[0], 32'h00);

        send(2, 16'h3132, 1'b0); send(2, 16'h3334, 1'b0);
        send(2, 16'h3536, 1'b0); send(2, 16'h3738, 1'b1);

        send_str(1, "123456789", 1'b1);
        chk("crc16 result", res_a[1], 32'h29B1);
        chk("crc16 crc_o back to init", crc_a[1], 32'hFFFF);

        send_str(3, "123456789", 1'b1);
        chk("crc32 result", res_a[3], 32'hCBF4_3926);

        // Backpressure: held result stalls input, then HOLD->HOLD handover.
        repeat (2) @(negedge clk);
        rr[0] = 1'b0;
        send(0, 16'h01, 1'b1);
        chk("bp result 0x01", res_a[0], 32'h07);
        repeat (3) @(negedge clk);
        chk("bp ready low", 32'(rdy[0]), 32'h0);
        chk("bp result held", res_a[0], 32'h07);
        d0 = 8'h02; dv[0] = 1'b1; dl[0] = 1'b1;
        @(negedge clk);
        chk("bp still stalled", 32'(vld[0]), 32'h1);
        rr[0] = 1'b1;
        @(negedge clk);
        dv[0] = 1'b0; dl[0] = 1'b0;
        chk("handover result", res_a[0], 32'h0E);
        chk("handover valid", 32'(vld[0]), 32'h1);

        send(0, 16'h01, 1'b1);
        chk("b2b first", res_a[0], 32'h07);
        send(0, 16'h02, 1'b1);
        chk("b2b second", res_a[0], 32'h0E);

        // Frame carrying its own CRC, good then corrupted.
        send_str(0, "123456789", 1'b0);
        send(0, 16'hF4, 1'b1);
        chk("residue good result", res_a[0], 32'h00);
`ifdef CRC_STREAM_CHECK_EN
        chk("residue good match", 32'(mt[0]), 32'h1);
`endif
        send_str(0, "123456789", 1'b0);
        send(0, 16'hF5, 1'b1);
        chk("residue bad result", res_a[0], 32'h07);
`ifdef CRC_STREAM_CHECK_EN
        chk("residue bad match", 32'(mt[0]), 32'h0);
`endif

        // Reset mid-frame with a last word offered during reset.
        @(negedge clk);
        send_str(0, "1234", 1'b0);
        rst[0] = 1'b1; d0 = 8'h35; dv[0] = 1'b1; dl[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0; dv[0] = 1'b0; dl[0] = 1'b0;
        chk("mid reset crc_o", crc_a[0], 32'h00);
        chk("mid reset no result", 32'(vld[0]), 32'h0);
        @(negedge clk);
        chk("mid reset still no result", 32'(vld[0]), 32'h0);
        send_str(0, "123456789", 1'b1);
        chk("after reset result", res_a[0], 32'hF4);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
